ripple_count_capture: RTL and testbench

Downstream stage of the 4-bit ripple counter. Samples the counter's asynchronous, ripple-skewed output bits into the `CLK` domain. Accepts a value only after it has been stable long enough to exclude ripple transients. Each accepted change is delivered to the consumer over a valid/ready handshake.

---
 rtl/ripple_count_capture.sv | 174 +++++++++++++++++
 tb/tb_ripple_count_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// ripple_count_capture
//
// Captures the output of a free-running 4-bit ripple counter into the CLK domain.
// The raw bits are synchronized and then filtered. A value is accepted only after it
// has been seen unchanged for STABLE_CYCLES consecutive synchronized samples, which
// rejects ripple transients. Each accepted value that differs from the last transferred
// value is handed to the consumer over a valid/ready handshake.
//
// Optional feature (macro CAPTURE_DELTA_EN): when defined, delta_out and wrap report
// how far the counter advanced since the last transfer.
//
// Parameters
//   WIDTH          width of the captured count
//   STABLE_CYCLES  identical synchronized samples needed to accept a value (2..15)
// Ports
//   CLK          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Q_in         raw ripple-counter bits, asynchronous to CLK
//   out_ready    consumer accepts count_out this cycle
//   count_valid  count_out holds an unconsumed accepted value
//   count_out    accepted count value
//   overrun      sticky: an accepted value was superseded before transfer
//   delta_out    (CAPTURE_DELTA_EN) count_out - last_sent, modulo 2^WIDTH
//   wrap         (CAPTURE_DELTA_EN) count_out < last_sent

module ripple_count_capture #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             out_ready,
  output logic             count_valid,
  output logic [WIDTH-1:0] count_out,
  output logic             overrun
`ifdef CAPTURE_DELTA_EN
  ,
  output logic [WIDTH-1:0] delta_out,
  output logic             wrap
`endif
);

  // Four bits cover the full legal STABLE_CYCLES range.
  localparam logic [3:0] StabMax = 4'(STABLE_CYCLES);
  localparam logic [3:0] StabAcc = 4'(STABLE_CYCLES - 1);

  typedef enum logic {StIdle, StPresent} state_e;

  // Synchronizer
  logic [WIDTH-1:0] sync1_q, sync_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= Q_in;
      sync_q  <= sync1_q;
    end
  end

  // Stability filter
  logic [WIDTH-1:0] candidate_q, candidate_d;
  logic [3:0]       stab_cnt_q, stab_cnt_d;
  logic             match, accept;

  always_comb begin
    candidate_d = candidate_q;
    stab_cnt_d  = stab_cnt_q;
    match       = (sync_q == candidate_q);
    // Fires exactly once per stable run because the counter saturates past StabAcc.
    accept      = match && (stab_cnt_q == StabAcc);
    if (!match) begin
      candidate_d = sync_q;
      stab_cnt_d  = 4'd1;
    end else if (stab_cnt_q < StabMax) begin
      stab_cnt_d  = stab_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      candidate_q <= '0;
      stab_cnt_q  <= '0;
    end else begin
      candidate_q <= candidate_d;
      stab_cnt_q  <= stab_cnt_d;
    end
  end

  // Output handshake
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_sent_q, last_sent_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_vld_q, pending_vld_d;
  logic             overrun_q, overrun_d;
  logic             accept_new, transfer;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    last_sent_d   = last_sent_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    overrun_d     = overrun_q;
    // Re-acceptance of the value the consumer already has is not news.
    accept_new    = accept && (sync_q != last_sent_q);
    transfer      = (state_q == StPresent) && out_ready;

    unique case (state_q)
      StIdle: begin
        if (accept_new) begin
          count_d = sync_q;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (transfer) begin
          last_sent_d = count_q;
          if (pending_vld_q) begin
            // Older pending value goes out first; a simultaneous accept refills the slot.
            count_d = pending_q;
            if (accept_new) begin
              pending_d = sync_q;
            end else begin
              pending_vld_d = 1'b0;
            end
          end else if (accept_new) begin
            count_d = sync_q;
          end else begin
            state_d = StIdle;
          end
        end else if (accept_new) begin
          if (pending_vld_q) begin
            overrun_d = 1'b1;
          end
          pending_d     = sync_q;
          pending_vld_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      last_sent_q   <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      last_sent_q   <= last_sent_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      overrun_q     <= overrun_d;
    end
  end

  assign count_valid = (state_q == StPresent);
  assign count_out   = count_q;
  assign overrun     = overrun_q;

`ifdef CAPTURE_DELTA_EN
  assign delta_out = count_q - last_sent_q;
  assign wrap      = (count_q < last_sent_q);
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Self-checking bench for ripple_count_capture. A reference model decides, from run
// lengths of the driven Q_in, which values get accepted and queues the values the
// consumer should receive; a monitor compares the DUT against that queue every cycle.
module tb_ripple_count_capture;
  localparam int unsigned W = 4;
  localparam int unsigned S = 3;

  logic         CLK       = 1'b0;
  logic         Reset_n   = 1'b0;
  logic [W-1:0] Q_in      = '0;
  logic         out_ready = 1'b0;
  logic         count_valid;
  logic [W-1:0] count_out;
  logic         overrun;
`ifdef CAPTURE_DELTA_EN
  logic [W-1:0] delta_out;
  logic         wrap;
`endif

  always #5 CLK = ~CLK;

  ripple_count_capture #(
    .WIDTH        (W),
    .STABLE_CYCLES(S)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .Q_in       (Q_in),
    .out_ready  (out_ready),
    .count_valid(count_valid),
    .count_out  (count_out),
    .overrun    (overrun)
`ifdef CAPTURE_DELTA_EN
    ,
    .delta_out  (delta_out),
    .wrap       (wrap)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0] exp_q[$];       // head = value being presented, second = waiting value
  logic [W-1:0] ls_m     = '0;  // last value handed to the consumer
  bit           ovr_m    = 1'b0;
  bit           xfer_flag = 1'b0;
  logic [W-1:0] xfer_val = '0;
  logic [W-1:0] prev_q   = '0;
  int           run      = S;
  bit           d1v = 1'b0, d2v = 1'b0, av;
  logic [W-1:0] d1 = '0, d2 = '0, aval;

  // Model: a value held on Q_in for S sampling edges is accepted two edges later
  // (synchronizer latency). The output side is a two-deep buffer whose tail is
  // overwritten (overrun) when full.
  initial forever begin
    @(posedge CLK or negedge Reset_n);
    if (!Reset_n) begin
      exp_q.delete();
      ls_m = '0; ovr_m = 1'b0; xfer_flag = 1'b0;
      prev_q = '0; run = S; d1v = 1'b0; d2v = 1'b0;
    end else begin
      av = d2v; aval = d2;
      d2v = d1v; d2 = d1; d1v = 1'b0;
      if (Q_in == prev_q) begin
        if (run < S) begin
          run++;
          if (run == S) begin
            d1v = 1'b1;
            d1  = Q_in;
          end
        end
      end else begin
        prev_q = Q_in;
        run    = 1;
      end
      if (av && aval != ls_m) begin
        if (exp_q.size() >= 2) begin
          exp_q[1] = aval;
          ovr_m    = 1'b1;
        end else begin
          exp_q.push_back(aval);
        end
      end
      if (xfer_flag) begin
        ls_m      = xfer_val;
        xfer_flag = 1'b0;
      end
    end
  end

  // Monitor: sampled mid-cycle, after outputs settle and while inputs are stable.
  logic [W-1:0] exp_delta;
  initial forever begin
    @(negedge CLK);
    if (Reset_n) begin
      check("count_valid", int'(count_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("count_out", int'(count_out), int'(exp_q[0]));
`ifdef CAPTURE_DELTA_EN
        exp_delta = exp_q[0] - ls_m;
        check("delta_out", int'(delta_out), int'(exp_delta));
        check("wrap", int'(wrap), int'(exp_q[0] < ls_m));
`endif
        if (out_ready) begin
          xfer_val  = exp_q.pop_front();
          xfer_flag = 1'b1;
        end
      end
      check("overrun", int'(overrun), int'(ovr_m));
    end
  end

  task automatic step(input logic [W-1:0] q, input bit rdy);
    @(posedge CLK);
    #2;
    Q_in      = q;
    out_ready = rdy;
  endtask

  task automatic seg(input logic [W-1:0] q, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(q, rdy);
  endtask

  // Counts edges until count_valid rises, bounded.
  task automatic wait_valid(input string name, input int exp_edges);
    int got;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      #1;
      if (count_valid) begin
        got = i;
        break;
      end
    end
    check(name, got, exp_edges);
  endtask

  initial begin
    logic [W-1:0] v;
    int n;
    repeat (3) @(posedge CLK);
    #2 Reset_n = 1'b1;

    // Q_in = 0 after reset: nothing is ever presented.
    seg(4'd0, 20, 1'b1);

    // 0 -> 5 with consumer ready: valid after edge S+2, consumed on the next edge.
    step(4'd5, 1'b1);
    wait_valid("latency_5", S + 2);
    seg(4'd5, 5, 1'b1);

    // Ripple transient: 6 visible for two cycles only, then 7.
    seg(4'd6, 2, 1'b1);
    seg(4'd7, 10, 1'b1);

    // Consumer stalled while 1 -> 2 -> 3; 2 is displaced, then 1 and 3 drain.
    seg(4'd1, 10, 1'b0);
    seg(4'd2, 10, 1'b0);
    seg(4'd3, 10, 1'b0);
    seg(4'd3, 10, 1'b1);

    // Wrap past zero: last sent 14, then 2 presented while stalled.
    seg(4'd14, 10, 1'b1);
    seg(4'd2, 10, 1'b0);
    seg(4'd2, 5, 1'b1);

    // Reset pulse while a value is presented.
    seg(4'd9, 10, 1'b0);
    @(negedge CLK);
    #1 Reset_n = 1'b0;
    #1;
    check("rst_valid", int'(count_valid), 0);
    check("rst_count", int'(count_out), 0);
    check("rst_overrun", int'(overrun), 0);
    #1 Reset_n = 1'b1;
    wait_valid("latency_rst", S + 2);
    seg(4'd9, 5, 1'b1);

    // Randomized segments with a mostly-ready consumer.
    for (int k = 0; k < 200; k++) begin
      v = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 6);
      for (int c = 0; c < n; c++) step(v, $urandom_range(0, 3) != 0);
    end

    // Drain with a stable input and a ready consumer.
    seg(Q_in, 20, 1'b1);
    check("drained", exp_q.size(), 0);
    check("final_valid", int'(count_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
